alu_dispatch: RTL

- Initiator side of the 8-bit ALU operand/result interface (rs, rt, op in; alu_out back).
- Accepts ALU requests from the core's execute stage over valid/ready and buffers them in a small FIFO.
- Drives operands to the combinational ripple/array ALU and holds them stable for a per-op multicycle window.
- Captures alu_out and returns a tagged result to writeback over valid/ready.

---
 rtl/alu_dispatch_if.sv | 29 ++
 rtl/alu_dispatch.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/alu_dispatch_if.sv
// alu_dispatch_if: request/response handshake bundle between the execute
// stage (master) and the ALU dispatch block (slave).
//   req_*  : execute stage -> dispatch, valid/ready, op/rs/rt/tag payload
//   rsp_*  : dispatch -> writeback, valid/ready, data/tag/dz payload
interface alu_dispatch_if #(
  parameter int TAG_W = 4
);
  logic             req_valid;
  logic             req_ready;
  logic [1:0]       req_op;
  logic [7:0]       req_rs;
  logic [7:0]       req_rt;
  logic [TAG_W-1:0] req_tag;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [7:0]       rsp_data;
  logic [TAG_W-1:0] rsp_tag;
  logic             rsp_dz;

  modport master (
    output req_valid, req_op, req_rs, req_rt, req_tag, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_tag, rsp_dz
  );

  modport slave (
    input  req_valid, req_op, req_rs, req_rt, req_tag, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_tag, rsp_dz
  );
endinterface

// File: rtl/alu_dispatch.sv
// alu_dispatch: initiator side of the 8-bit ALU operand/result interface.
// Buffers requests in a DEPTH-entry FIFO, presents registered operands to an
// external combinational ALU for a per-op number of cycles, then captures the
// ALU result and returns it with its tag.
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   bus (slave)     : req_* valid/ready request channel, rsp_* valid/ready result channel
//   alu_rs/rt/op    : registered operands/opcode to the ALU
//   alu_out         : combinational ALU result
//   busy            : FSM not idle or FIFO non-empty
//   perf_ops        : completed-response counter (only with ALU_DISPATCH_PERF_EN)
// Optional feature macro: ALU_DISPATCH_PERF_EN.
module alu_dispatch #(
  parameter int DEPTH         = 2,
  parameter int TAG_W         = 4,
  parameter int ADDSUB_CYCLES = 1,
  parameter int MULDIV_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  alu_dispatch_if.slave bus,
  output logic [7:0] alu_rs,
  output logic [7:0] alu_rt,
  output logic [1:0] alu_op,
  input  logic [7:0] alu_out,
  output logic       busy
`ifdef ALU_DISPATCH_PERF_EN
  ,
  output logic [15:0] perf_ops
`endif
);

  localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int ENTRY_W = 18 + TAG_W;
  localparam int MAX_CYC = (ADDSUB_CYCLES > MULDIV_CYCLES) ? ADDSUB_CYCLES : MULDIV_CYCLES;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CNT_W-1:0] ADDSUB_LOAD = CNT_W'(ADDSUB_CYCLES - 1);
  localparam logic [CNT_W-1:0] MULDIV_LOAD = CNT_W'(MULDIV_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  // Request FIFO; pointers carry one extra wrap bit to tell full from empty.
  logic [ENTRY_W-1:0] fifo_mem [DEPTH];
  logic [PTR_W:0]     wr_ptr_reg, rd_ptr_reg;
  logic               full, empty, push, pop;
  logic [1:0]         head_op;
  logic [7:0]         head_rs, head_rt;
  logic [TAG_W-1:0]   head_tag;

  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[PTR_W] != rd_ptr_reg[PTR_W]) &&
                 (wr_ptr_reg[PTR_W-1:0] == rd_ptr_reg[PTR_W-1:0]);
  // req_ready depends only on registered fullness, so a pop in the same
  // cycle never lets an extra request in.
  assign push  = bus.req_valid && !full;
  assign bus.req_ready = !full;
  assign {head_op, head_rs, head_rt, head_tag} = fifo_mem[rd_ptr_reg[PTR_W-1:0]];

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg[PTR_W-1:0]] <= {bus.req_op, bus.req_rs, bus.req_rt, bus.req_tag};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  // FSM and datapath registers
  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [7:0]       alu_rs_reg, alu_rs_next, alu_rt_reg, alu_rt_next;
  logic [1:0]       alu_op_reg, alu_op_next;
  logic [TAG_W-1:0] tag_reg, tag_next;
  logic             rsp_valid_reg, rsp_valid_next, rsp_dz_reg, rsp_dz_next;
  logic [7:0]       rsp_data_reg, rsp_data_next;
  logic [TAG_W-1:0] rsp_tag_reg, rsp_tag_next;
  logic             load, div_zero;

  assign div_zero = (alu_op_reg == 2'b11) && (alu_rt_reg == 8'h00);

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    alu_rs_next    = alu_rs_reg;
    alu_rt_next    = alu_rt_reg;
    alu_op_next    = alu_op_reg;
    tag_next       = tag_reg;
    rsp_valid_next = rsp_valid_reg;
    rsp_data_next  = rsp_data_reg;
    rsp_tag_next   = rsp_tag_reg;
    rsp_dz_next    = rsp_dz_reg;
    load           = 1'b0;
    pop            = 1'b0;

    case (state_reg)
      IDLE: begin
        if (!empty) load = 1'b1;
      end
      EXEC: begin
        if (cnt_reg == '0) begin
          rsp_valid_next = 1'b1;
          rsp_data_next  = div_zero ? 8'hFF : alu_out;
          rsp_dz_next    = div_zero;
          rsp_tag_next   = tag_reg;
          state_next     = RESP;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_next = 1'b0;
          if (!empty) load = 1'b1;
          else        state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    // Operands only change here, so the ALU inputs are quiet otherwise.
    if (load) begin
      pop         = 1'b1;
      alu_rs_next = head_rs;
      alu_rt_next = head_rt;
      alu_op_next = head_op;
      tag_next    = head_tag;
      cnt_next    = head_op[1] ? MULDIV_LOAD : ADDSUB_LOAD;
      state_next  = EXEC;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      alu_rs_reg    <= '0;
      alu_rt_reg    <= '0;
      alu_op_reg    <= '0;
      tag_reg       <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_data_reg  <= '0;
      rsp_tag_reg   <= '0;
      rsp_dz_reg    <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      alu_rs_reg    <= alu_rs_next;
      alu_rt_reg    <= alu_rt_next;
      alu_op_reg    <= alu_op_next;
      tag_reg       <= tag_next;
      rsp_valid_reg <= rsp_valid_next;
      rsp_data_reg  <= rsp_data_next;
      rsp_tag_reg   <= rsp_tag_next;
      rsp_dz_reg    <= rsp_dz_next;
    end
  end

  assign alu_rs        = alu_rs_reg;
  assign alu_rt        = alu_rt_reg;
  assign alu_op        = alu_op_reg;
  assign bus.rsp_valid = rsp_valid_reg;
  assign bus.rsp_data  = rsp_data_reg;
  assign bus.rsp_tag   = rsp_tag_reg;
  assign bus.rsp_dz    = rsp_dz_reg;
  assign busy          = (state_reg != IDLE) || !empty;

`ifdef ALU_DISPATCH_PERF_EN
  logic [15:0] perf_ops_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_ops_reg <= '0;
    end else if (rsp_valid_reg && bus.rsp_ready && (perf_ops_reg != 16'hFFFF)) begin
      perf_ops_reg <= perf_ops_reg + 16'd1;
    end
  end

  assign perf_ops = perf_ops_reg;
`endif

endmodule
